// File: rtl/my_core_tracer_defines.sv
// Shared types for the retire trace path: instruction classes, trace record layout
// and the wildcard-based RV32I classifier.
package my_core_tracer_defines;

  typedef enum logic [3:0] {
    CLS_U, CLS_J, CLS_JALR, CLS_BRANCH, CLS_ALU_I, CLS_ALU_R,
    CLS_CSR, CLS_ECALL, CLS_MRET, CLS_WFI, CLS_OTHER
  } trace_cls_e;

  typedef enum logic {GAP_CLEAR, GAP_PENDING} gap_state_e;

  typedef struct packed {
    logic [31:0] cycle;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rd_wdata;
    logic [4:0]  rd_addr;
    logic        rd_we;
    trace_cls_e  cls;
    logic        gap;
  } trace_rec_t;

  localparam int TRACE_REC_W = $bits(trace_rec_t);

  // Priority order matters: the exact SYSTEM encodings must win over the CSR opcode.
  function automatic trace_cls_e classify(input logic [31:0] instr);
    trace_cls_e cls;
    if (instr ==? 32'h0000_0073) cls = CLS_ECALL;
    else if (instr ==? 32'h3020_0073) cls = CLS_MRET;
    else if (instr ==? 32'h1050_0073) cls = CLS_WFI;
    else if ((instr ==? 32'b???????_?????_?????_001_?????_1110011) ||
             (instr ==? 32'b???????_?????_?????_010_?????_1110011) ||
             (instr ==? 32'b???????_?????_?????_011_?????_1110011) ||
             (instr ==? 32'b???????_?????_?????_101_?????_1110011) ||
             (instr ==? 32'b???????_?????_?????_110_?????_1110011) ||
             (instr ==? 32'b???????_?????_?????_111_?????_1110011)) cls = CLS_CSR;
    else if ((instr ==? 32'b???????_?????_?????_???_?????_0110111) ||
             (instr ==? 32'b???????_?????_?????_???_?????_0010111)) cls = CLS_U;
    else if (instr ==? 32'b???????_?????_?????_???_?????_1101111) cls = CLS_J;
    else if (instr ==? 32'b???????_?????_?????_000_?????_1100111) cls = CLS_JALR;
    else if ((instr ==? 32'b???????_?????_?????_000_?????_1100011) ||
             (instr ==? 32'b???????_?????_?????_001_?????_1100011) ||
             (instr ==? 32'b???????_?????_?????_100_?????_1100011) ||
             (instr ==? 32'b???????_?????_?????_101_?????_1100011) ||
             (instr ==? 32'b???????_?????_?????_110_?????_1100011) ||
             (instr ==? 32'b???????_?????_?????_111_?????_1100011)) cls = CLS_BRANCH;
    else if ((instr ==? 32'b???????_?????_?????_000_?????_0010011) ||
             (instr ==? 32'b???????_?????_?????_010_?????_0010011) ||
             (instr ==? 32'b???????_?????_?????_011_?????_0010011) ||
             (instr ==? 32'b???????_?????_?????_100_?????_0010011) ||
             (instr ==? 32'b???????_?????_?????_110_?????_0010011) ||
             (instr ==? 32'b???????_?????_?????_111_?????_0010011) ||
             (instr ==? 32'b0000000_?????_?????_001_?????_0010011) ||
             (instr ==? 32'b0000000_?????_?????_101_?????_0010011) ||
             (instr ==? 32'b0100000_?????_?????_101_?????_0010011)) cls = CLS_ALU_I;
    else if ((instr ==? 32'b0000000_?????_?????_000_?????_0110011) ||
             (instr ==? 32'b0100000_?????_?????_000_?????_0110011) ||
             (instr ==? 32'b0000000_?????_?????_001_?????_0110011) ||
             (instr ==? 32'b0000000_?????_?????_010_?????_0110011) ||
             (instr ==? 32'b0000000_?????_?????_011_?????_0110011) ||
             (instr ==? 32'b0000000_?????_?????_100_?????_0110011) ||
             (instr ==? 32'b0000000_?????_?????_101_?????_0110011) ||
             (instr ==? 32'b0100000_?????_?????_101_?????_0110011) ||
             (instr ==? 32'b0000000_?????_?????_110_?????_0110011) ||
             (instr ==? 32'b0000000_?????_?????_111_?????_0110011)) cls = CLS_ALU_R;
    else cls = CLS_OTHER;
    return cls;
  endfunction

endpackage

// File: rtl/my_core_trace_fifo.sv
// Generic synchronous FIFO with flush; 1-cycle first-word-through, push refused when full
// unless a pop happens in the same cycle.
module my_core_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o   = count_q;
  // Drive zero when empty so the output is clean after reset/flush.
  assign pop_dat_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_dat_i;
        wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/my_core_retire_trace_buf.sv
// Classifies and cycle-stamps retired instructions into a FIFO drained over valid/ready;
// 1-cycle first-word-through, records arriving at a full FIFO without a pop are counted as drops.
module my_core_retire_trace_buf
  import my_core_tracer_defines::*;
#(
  parameter int DEPTH      = 8,
  parameter int DROP_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    trace_en_i,
  input  logic                    flush_i,
  input  logic                    ret_valid_i,
  input  logic [31:0]             ret_pc_i,
  input  logic [31:0]             ret_instr_i,
  input  logic                    ret_rd_we_i,
  input  logic [4:0]              ret_rd_addr_i,
  input  logic [31:0]             ret_rd_wdata_i,
  output logic                    trc_valid_o,
  input  logic                    trc_ready_i,
  output trace_rec_t              trc_rec_o,
  output logic [DROP_CNT_W-1:0]   drop_cnt_o,
  output logic                    overflow_o,
  output logic [$clog2(DEPTH):0]  fill_o
);
  logic [31:0]            cycle_q, cycle_d;
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic                   overflow_q, overflow_d;
  gap_state_e             gap_q, gap_d;
  logic                   push, pop, drop, fifo_push, fifo_full, fifo_empty;
  trace_rec_t             rec_in;
  logic [TRACE_REC_W-1:0] fifo_dat;

  always_comb begin
    push      = ret_valid_i & trace_en_i & ~flush_i;
    pop       = ~fifo_empty & trc_ready_i;
    // A pop in the same cycle frees the slot, so only push-into-full-without-pop loses data.
    drop      = push & fifo_full & ~pop;
    fifo_push = push & ~drop;

    rec_in.cycle    = cycle_q;
    rec_in.pc       = ret_pc_i;
    rec_in.instr    = ret_instr_i;
    rec_in.rd_wdata = ret_rd_wdata_i;
    rec_in.rd_addr  = ret_rd_addr_i;
    rec_in.rd_we    = ret_rd_we_i;
    rec_in.cls      = classify(ret_instr_i);
    rec_in.gap      = (gap_q == GAP_PENDING);

    cycle_d    = cycle_q + 32'd1;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (~&drop_cnt_q) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_comb begin
    gap_d = gap_q;
    unique case (gap_q)
      GAP_CLEAR:   if (drop) gap_d = GAP_PENDING;
      GAP_PENDING: if (flush_i || fifo_push) gap_d = GAP_CLEAR;
      default:     gap_d = GAP_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
      gap_q      <= GAP_CLEAR;
    end else begin
      cycle_q    <= cycle_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
      gap_q      <= gap_d;
    end
  end

  my_core_trace_fifo #(
    .WIDTH (TRACE_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .push_i     (fifo_push),
    .push_dat_i (rec_in),
    .pop_i      (pop),
    .pop_dat_o  (fifo_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fill_o)
  );

  assign trc_valid_o = ~fifo_empty;
  assign trc_rec_o   = trace_rec_t'(fifo_dat);
  assign drop_cnt_o  = drop_cnt_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_my_core_retire_trace_buf.sv
// Randomized bench for the retire trace buffer against a queue-based reference model.
module tb_my_core_retire_trace_buf;
  import my_core_tracer_defines::*;

  localparam int DEPTH = 8;
  localparam int DW    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trace_en_i = 1'b0, flush_i = 1'b0, ret_valid_i = 1'b0;
  logic [31:0] ret_pc_i = '0, ret_instr_i = '0, ret_rd_wdata_i = '0;
  logic        ret_rd_we_i = 1'b0;
  logic [4:0]  ret_rd_addr_i = '0;
  logic        trc_valid_o, trc_ready_i = 1'b0, overflow_o;
  trace_rec_t  trc_rec_o;
  logic [DW-1:0] drop_cnt_o;
  logic [$clog2(DEPTH):0] fill_o;

  my_core_retire_trace_buf #(.DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .trace_en_i(trace_en_i), .flush_i(flush_i),
    .ret_valid_i(ret_valid_i), .ret_pc_i(ret_pc_i), .ret_instr_i(ret_instr_i),
    .ret_rd_we_i(ret_rd_we_i), .ret_rd_addr_i(ret_rd_addr_i), .ret_rd_wdata_i(ret_rd_wdata_i),
    .trc_valid_o(trc_valid_o), .trc_ready_i(trc_ready_i), .trc_rec_o(trc_rec_o),
    .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o), .fill_o(fill_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  trace_rec_t  mq[$];
  int unsigned m_cycle = 0;
  int unsigned m_drop  = 0;
  bit          m_ovf = 0, m_gp = 0, m_known = 0;

  task automatic chk(input string tag, input logic [138:0] obs, input logic [138:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Field-decoded reference classifier (opcode/funct3/funct7), independent of the bit patterns.
  function automatic trace_cls_e ref_cls(input logic [31:0] i);
    logic [6:0] op = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    if (i == 32'h0000_0073) return CLS_ECALL;
    if (i == 32'h3020_0073) return CLS_MRET;
    if (i == 32'h1050_0073) return CLS_WFI;
    case (op)
      7'h73: return (f3 != 3'd0 && f3 != 3'd4) ? CLS_CSR : CLS_OTHER;
      7'h37, 7'h17: return CLS_U;
      7'h6F: return CLS_J;
      7'h67: return (f3 == 3'd0) ? CLS_JALR : CLS_OTHER;
      7'h63: return (f3 != 3'd2 && f3 != 3'd3) ? CLS_BRANCH : CLS_OTHER;
      7'h13: begin
        if (f3 == 3'd1) return (f7 == 7'h00) ? CLS_ALU_I : CLS_OTHER;
        if (f3 == 3'd5) return (f7 == 7'h00 || f7 == 7'h20) ? CLS_ALU_I : CLS_OTHER;
        return CLS_ALU_I;
      end
      7'h33: begin
        if (f7 == 7'h00) return CLS_ALU_R;
        if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return CLS_ALU_R;
        return CLS_OTHER;
      end
      default: return CLS_OTHER;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 14))
      0: return 32'h0000_0073;
      1: return 32'h3020_0073;
      2: return 32'h1050_0073;
      3: r[6:0] = 7'h73;
      4: r[6:0] = 7'h37;
      5: r[6:0] = 7'h17;
      6: r[6:0] = 7'h6F;
      7: r[6:0] = 7'h67;
      8: r[6:0] = 7'h63;
      9, 10: r[6:0] = 7'h13;
      11, 12: r[6:0] = 7'h33;
      13: r[6:0] = 7'h03;
      default: ;
    endcase
    if ($urandom_range(0, 2) != 0) r[31:25] = $urandom_range(0, 1) ? 7'h00 : 7'h20;
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit         pop, push, full;
    trace_rec_t r;
    if (!rst_n) begin
      mq.delete();
      m_cycle = 0; m_drop = 0; m_ovf = 0; m_gp = 0; m_known = 1;
      return;
    end
    pop  = (mq.size() > 0) && trc_ready_i;
    full = (mq.size() == DEPTH);
    push = ret_valid_i && trace_en_i && !flush_i;
    r.cycle = m_cycle; r.pc = ret_pc_i; r.instr = ret_instr_i;
    r.rd_wdata = ret_rd_wdata_i; r.rd_addr = ret_rd_addr_i; r.rd_we = ret_rd_we_i;
    r.cls = ref_cls(ret_instr_i); r.gap = m_gp;
    m_cycle++;
    if (flush_i) begin
      mq.delete(); m_drop = 0; m_ovf = 0; m_gp = 0;
      return;
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (full && !pop) begin
        if (m_drop < (1 << DW) - 1) m_drop++;
        m_ovf = 1; m_gp = 1;
      end else begin
        mq.push_back(r);
        m_gp = 0;
      end
    end
  endtask

  task automatic check_model();
    if (!m_known) return;
    chk("valid", trc_valid_o, mq.size() > 0);
    chk("fill", fill_o, mq.size());
    chk("drop_cnt", drop_cnt_o, m_drop);
    chk("overflow", overflow_o, m_ovf);
    if (mq.size() > 0) chk("rec", trc_rec_o, mq[0]);
  endtask

  task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic [31:0] wd, input bit rdy, input bit en,
                     input bit fl, input bit rs);
    ret_valid_i = v; ret_instr_i = ins; ret_pc_i = pc; ret_rd_wdata_i = wd;
    ret_rd_addr_i = ins[11:7]; ret_rd_we_i = (ins[11:7] != 5'd0);
    trc_ready_i = rdy; trace_en_i = en; flush_i = fl; rst_n = ~rs;
    model_step();
    @(posedge clk); #1;
    check_model();
  endtask

  task automatic ret(input logic [31:0] ins, input bit rdy);
    cyc(1'b1, ins, $urandom, $urandom, rdy, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input bit rdy);
    cyc(1'b0, 32'h0000_0013, 32'h0, 32'h0, rdy, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cf;
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("reset_rec", trc_rec_o, '0);
    idle(1); idle(1); idle(1);

    cyc(1'b1, 32'h0050_0093, 32'h100, 32'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("addi_valid", trc_valid_o, 1);
    chk("addi_cls", trc_rec_o.cls, CLS_ALU_I);
    chk("addi_pc", trc_rec_o.pc, 32'h100);
    chk("addi_rd", trc_rec_o.rd_addr, 5'd1);
    chk("addi_wdata", trc_rec_o.rd_wdata, 32'd5);
    chk("addi_cycle", trc_rec_o.cycle, 32'd3);
    chk("addi_gap", trc_rec_o.gap, 0);

    ret(32'h0000_0073, 1); chk("cls_ecall", trc_rec_o.cls, CLS_ECALL);
    ret(32'h3020_0073, 1); chk("cls_mret",  trc_rec_o.cls, CLS_MRET);
    ret(32'h1050_0073, 1); chk("cls_wfi",   trc_rec_o.cls, CLS_WFI);
    ret(32'h3004_7073, 1); chk("cls_csr",   trc_rec_o.cls, CLS_CSR);
    ret(32'h4020_8033, 1); chk("cls_sub",   trc_rec_o.cls, CLS_ALU_R);
    ret(32'h0000_2083, 1); chk("cls_lw",    trc_rec_o.cls, CLS_OTHER);
    ret(32'h0000_006F, 1); chk("cls_jal",   trc_rec_o.cls, CLS_J);
    idle(1); idle(1);

    for (int i = 0; i < 11; i++) ret(rand_instr(), 0);
    chk("ovf_fill", fill_o, 8);
    chk("ovf_drops", drop_cnt_o, 3);
    chk("ovf_sticky", overflow_o, 1);
    ret(rand_instr(), 1);
    for (int i = 0; i < 7; i++) idle(1);
    chk("gap_valid", trc_valid_o, 1);
    chk("gap_flag", trc_rec_o.gap, 1);
    idle(1); idle(1);

    for (int i = 0; i < 8; i++) ret(rand_instr(), 0);
    for (int i = 0; i < 5; i++) begin
      ret(rand_instr(), 1);
      chk("full_pp_fill", fill_o, 8);
      chk("full_pp_drop", drop_cnt_o, 3);
    end

    cyc(1'b0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) ret(rand_instr(), 0);
    cf = m_cycle;
    cyc(1'b1, rand_instr(), $urandom, $urandom, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("flush_fill", fill_o, 0);
    chk("flush_valid", trc_valid_o, 0);
    chk("flush_drop", drop_cnt_o, 0);
    chk("flush_ovf", overflow_o, 0);
    ret(32'h0050_0093, 0);
    chk("flush_cycle_runs", trc_rec_o.cycle, cf + 1);

    for (int i = 0; i < 4; i++) ret(rand_instr(), 0);
    chk("pre_rst_fill", fill_o, 5);
    cyc(1'b1, rand_instr(), $urandom, $urandom, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_valid", trc_valid_o, 0);
    chk("rst_fill", fill_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_rec", trc_rec_o, '0);
    ret(32'h0000_0013, 0);
    chk("rst_cycle0", trc_rec_o.cycle, 0);
    for (int i = 0; i < 12; i++)
      cyc(1'b1, rand_instr(), $urandom, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("en_off_fill", fill_o, 1);
    chk("en_off_drop", drop_cnt_o, 0);

    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom,
          $urandom_range(0, 1), $urandom_range(0, 9) != 0,
          $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
